// File: rtl/traffic_conflict_monitor_if.sv
// Lamp-side bus between the intersection controller and the conflict monitor:
// sampled lamp drives, tick and clear in; latched fault status and flash override out.
interface traffic_conflict_monitor_if;
  logic       i_tick;
  logic       i_ns_red;
  logic       i_ns_yel;
  logic       i_ns_grn;
  logic       i_ew_red;
  logic       i_ew_yel;
  logic       i_ew_grn;
  logic       i_clr_fault;
  logic       o_fault;
  logic [2:0] o_fault_code;
  logic       o_flash;
  logic [1:0] o_mon_state;

  modport master (
    output i_tick, i_ns_red, i_ns_yel, i_ns_grn,
    output i_ew_red, i_ew_yel, i_ew_grn, i_clr_fault,
    input  o_fault, o_fault_code, o_flash, o_mon_state
  );

  modport slave (
    input  i_tick, i_ns_red, i_ns_yel, i_ns_grn,
    input  i_ew_red, i_ew_yel, i_ew_grn, i_clr_fault,
    output o_fault, o_fault_code, o_flash, o_mon_state
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Independent lamp-side safety checker: validates both signal heads against the
// legal plan every clock and latches the first violation with a flashing-yellow override.
module traffic_conflict_monitor #(
  parameter int MIN_YEL = 2,
  parameter int MAX_YEL = 5,
  parameter int MAX_GRN = 30,
  parameter int CNT_W   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  traffic_conflict_monitor_if.slave   bus
);

  typedef enum logic [1:0] {COL_RED = 2'd0, COL_YEL = 2'd1, COL_GRN = 2'd2, COL_BAD = 2'd3} colour_t;
  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_RUN = 2'd1, ST_FAULT = 2'd2} state_t;

  // Lamp vectors are {red, yel, grn}; index 0 is NS, index 1 is EW.
  function automatic colour_t decode(input logic [2:0] lamps);
    case (lamps)
      3'b100:  decode = COL_RED;
      3'b010:  decode = COL_YEL;
      3'b001:  decode = COL_GRN;
      default: decode = COL_BAD;
    endcase
  endfunction

  logic [2:0]       r_lamps [2];
  colour_t          r_pcol  [2];
  logic [CNT_W-1:0] r_dur   [2];
  logic             r_seed  [2];
  state_t           r_state;
  logic             r_fault;
  logic [2:0]       r_code;
  logic             r_flash;

  colour_t          w_col        [2];
  logic             w_multi      [2];
  logic             w_dark       [2];
  logic             w_go         [2];
  logic             w_change     [2];
  logic             w_bad_seq    [2];
  logic             w_short_yel  [2];
  logic             w_long_grn   [2];
  logic             w_long_yel   [2];
  logic [CNT_W-1:0] w_dur_inc    [2];
  logic [CNT_W-1:0] w_dur_upd    [2];
  colour_t          w_pcol_next  [2];
  logic [CNT_W-1:0] w_dur_next   [2];
  logic             w_seed_next  [2];
  logic             w_seeded_now [2];

  logic [7:1] w_viol;
  logic [7:1] w_active;
  logic [2:0] w_first_code;
  logic       w_clear;
  state_t     w_state_next;
  logic       w_fault_next;
  logic [2:0] w_code_next;
  logic       w_flash_next;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lamps[0] <= 3'b000;
      r_lamps[1] <= 3'b000;
    end else begin
      r_lamps[0] <= {bus.i_ns_red, bus.i_ns_yel, bus.i_ns_grn};
      r_lamps[1] <= {bus.i_ew_red, bus.i_ew_yel, bus.i_ew_grn};
    end
  end

  assign w_clear = (r_state == ST_FAULT) && bus.i_clr_fault;

  // A colour change beats a coincident tick, and the duration checks look at
  // the post-update count so long phases fire on the tick that crosses the limit.
  always_comb begin
    for (int h = 0; h < 2; h++) begin
      w_col[h]        = decode(r_lamps[h]);
      w_multi[h]      = $countones(r_lamps[h]) > 1;
      w_dark[h]       = (r_lamps[h] == 3'b000);
      w_go[h]         = r_lamps[h][1] | r_lamps[h][0];
      w_change[h]     = (w_col[h] != r_pcol[h]);
      w_dur_inc[h]    = (&r_dur[h]) ? r_dur[h] : r_dur[h] + CNT_W'(1);
      w_dur_upd[h]    = w_change[h] ? '0 : (bus.i_tick ? w_dur_inc[h] : r_dur[h]);
      w_bad_seq[h]    = w_change[h] &&
                        !((r_pcol[h] == COL_GRN && w_col[h] == COL_YEL) ||
                          (r_pcol[h] == COL_YEL && w_col[h] == COL_RED) ||
                          (r_pcol[h] == COL_RED && w_col[h] == COL_GRN));
      w_short_yel[h]  = (r_pcol[h] == COL_YEL) && (w_col[h] == COL_RED) &&
                        (r_dur[h] < CNT_W'(MIN_YEL));
      w_long_grn[h]   = (w_col[h] == COL_GRN) && (w_dur_upd[h] > CNT_W'(MAX_GRN));
      w_long_yel[h]   = (w_col[h] == COL_YEL) && (w_dur_upd[h] > CNT_W'(MAX_YEL));
      w_seeded_now[h] = r_seed[h] || (w_col[h] != COL_BAD);

      w_pcol_next[h] = r_pcol[h];
      w_dur_next[h]  = r_dur[h];
      w_seed_next[h] = r_seed[h];
      if (w_clear) begin
        w_pcol_next[h] = COL_RED;
        w_dur_next[h]  = '0;
        w_seed_next[h] = 1'b0;
      end else if (!r_seed[h]) begin
        if (w_col[h] != COL_BAD) begin
          w_pcol_next[h] = w_col[h];
          w_seed_next[h] = 1'b1;
        end
        w_dur_next[h] = '0;
      end else begin
        if (w_col[h] != COL_BAD) begin
          w_pcol_next[h] = w_col[h];
        end
        w_dur_next[h] = w_dur_upd[h];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int h = 0; h < 2; h++) begin
        r_pcol[h] <= COL_RED;
        r_dur[h]  <= '0;
        r_seed[h] <= 1'b0;
      end
    end else begin
      for (int h = 0; h < 2; h++) begin
        r_pcol[h] <= w_pcol_next[h];
        r_dur[h]  <= w_dur_next[h];
        r_seed[h] <= w_seed_next[h];
      end
    end
  end

  // Sequence and duration checks depend on seeded history, so only RUN trusts them.
  always_comb begin
    w_viol[1] = w_go[0] && w_go[1];
    w_viol[2] = w_multi[0] || w_multi[1];
    w_viol[3] = w_dark[0] || w_dark[1];
    w_viol[4] = w_bad_seq[0] || w_bad_seq[1];
    w_viol[5] = w_short_yel[0] || w_short_yel[1];
    w_viol[6] = w_long_grn[0] || w_long_grn[1];
    w_viol[7] = w_long_yel[0] || w_long_yel[1];
    w_active  = (r_state == ST_RUN) ? w_viol : {4'b0000, w_viol[3:1]};
    w_first_code = 3'd0;
    for (int c = 7; c >= 1; c--) begin
      if (w_active[c]) begin
        w_first_code = 3'(c);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_fault_next = r_fault;
    w_code_next  = r_code;
    w_flash_next = r_flash;
    case (r_state)
      ST_INIT, ST_RUN: begin
        if (w_first_code != 3'd0) begin
          w_state_next = ST_FAULT;
          w_fault_next = 1'b1;
          w_code_next  = w_first_code;
          w_flash_next = 1'b1;
        end else if (r_state == ST_INIT && w_seeded_now[0] && w_seeded_now[1]) begin
          w_state_next = ST_RUN;
        end
      end
      ST_FAULT: begin
        if (bus.i_clr_fault) begin
          w_state_next = ST_INIT;
          w_fault_next = 1'b0;
          w_code_next  = 3'd0;
          w_flash_next = 1'b0;
        end else if (bus.i_tick) begin
          w_flash_next = ~r_flash;
        end
      end
      default: begin
        w_state_next = ST_INIT;
        w_fault_next = 1'b0;
        w_code_next  = 3'd0;
        w_flash_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_INIT;
      r_fault <= 1'b0;
      r_code  <= 3'd0;
      r_flash <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_fault <= w_fault_next;
      r_code  <= w_code_next;
      r_flash <= w_flash_next;
    end
  end

  assign bus.o_fault      = r_fault;
  assign bus.o_fault_code = r_code;
  assign bus.o_flash      = r_flash;
  assign bus.o_mon_state  = r_state;

endmodule
